mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between instruction fetch and data access.
// Data requests take priority over fetches. Each transfer ends with a one-cycle ack,
// and a transfer that waits too long on bus_ready is aborted.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word data accesses fault without
// a bus cycle instead of being forced to an aligned address.
module mem_bus_arbiter #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [1:0]  dm_size,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        dm_fault,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_strb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        stall_f,
    output logic        stall_m,
    output logic        bus_err
);
    localparam int unsigned WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WW-1:0] LAST_WAIT = WW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          valid_q, valid_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    strb_q, strb_d;
    logic          sel_dm_q, sel_dm_d;
    logic [1:0]    size_q, size_d;
    logic [1:0]    off_q, off_d;
    logic          err_q, err_d;
    logic          fault_q, fault_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;

    logic          dm_go;
    logic          trap;
    logic [1:0]    dm_off;
    logic [3:0]    dm_strb;
    logic [31:0]   dm_wrep;
    logic [31:0]   rd_mask;
    logic [31:0]   rd_lane;
    logic          unused_if_lo;

    assign dm_go        = dm_req && (dm_size != 2'b00);
    assign unused_if_lo = ^if_addr[1:0];

`ifdef MISALIGN_TRAP_EN
    assign trap     = ((dm_size == 2'b10) && dm_addr[0]) ||
                      ((dm_size == 2'b11) && (dm_addr[1:0] != 2'b00));
    assign dm_fault = (state_q == RESP) && fault_q;
`else
    logic unused_fault;
    assign trap         = 1'b0;
    assign dm_fault     = 1'b0;
    assign unused_fault = fault_q;
`endif

    // Byte lane, strobes and replicated store data for the incoming data request.
    // The lane offset drops the low address bits a half/word access cannot use,
    // which also produces the forced alignment when trapping is disabled.
    always_comb begin
        dm_off  = 2'b00;
        dm_strb = 4'b1111;
        dm_wrep = dm_wdata;
        case (dm_size)
            2'b01: begin
                dm_off  = dm_addr[1:0];
                dm_strb = 4'b0001 << dm_addr[1:0];
                dm_wrep = {4{dm_wdata[7:0]}};
            end
            2'b10: begin
                dm_off  = {dm_addr[1], 1'b0};
                dm_strb = 4'b0011 << {dm_addr[1], 1'b0};
                dm_wrep = {2{dm_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Extract the accessed lane from the returned word, zero-extended.
    always_comb begin
        case (size_q)
            2'b01:   rd_mask = 32'h0000_00FF;
            2'b10:   rd_mask = 32'h0000_FFFF;
            default: rd_mask = 32'hFFFF_FFFF;
        endcase
        rd_lane = (bus_rdata >> {off_q, 3'b000}) & rd_mask;
    end

    // Next-state logic: arbitration in IDLE, handshake/timeout while on the bus.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        valid_d    = valid_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        sel_dm_d   = sel_dm_q;
        size_d     = size_q;
        off_d      = off_q;
        err_d      = err_q;
        fault_d    = fault_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            IDLE: begin
                wait_d  = '0;
                err_d   = 1'b0;
                fault_d = 1'b0;
                if (dm_go) begin
                    sel_dm_d = 1'b1;
                    size_d   = dm_size;
                    off_d    = dm_off;
                    if (trap) begin
                        state_d = RESP;
                        fault_d = 1'b1;
                    end else begin
                        state_d = DATA;
                        valid_d = 1'b1;
                        we_d    = dm_we;
                        addr_d  = {dm_addr[31:2], 2'b00};
                        wdata_d = dm_wrep;
                        strb_d  = dm_strb;
                    end
                end else if (if_req) begin
                    sel_dm_d = 1'b0;
                    state_d  = FETCH;
                    valid_d  = 1'b1;
                    we_d     = 1'b0;
                    addr_d   = {if_addr[31:2], 2'b00};
                    strb_d   = '1;
                end
            end
            FETCH, DATA: begin
                if (bus_ready) begin
                    state_d = RESP;
                    valid_d = 1'b0;
                    if (sel_dm_q) dm_rdata_d = rd_lane;
                    else          if_rdata_d = bus_rdata;
                end else if (wait_q == LAST_WAIT) begin
                    state_d = RESP;
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    if (sel_dm_q) dm_rdata_d = '0;
                    else          if_rdata_d = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            valid_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            sel_dm_q   <= 1'b0;
            size_q     <= '0;
            off_q      <= '0;
            err_q      <= 1'b0;
            fault_q    <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            valid_q    <= valid_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            sel_dm_q   <= sel_dm_d;
            size_q     <= size_d;
            off_q      <= off_d;
            err_q      <= err_d;
            fault_q    <= fault_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign bus_valid = valid_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_strb  = strb_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ack    = (state_q == RESP) && !sel_dm_q;
    assign dm_ack    = (state_q == RESP) && sel_dm_q;
    assign bus_err   = (state_q == RESP) && err_q;
    assign stall_f   = if_req && !if_ack;
    assign stall_m   = dm_go && !dm_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed transactions, a transaction-level reference
// model checked every cycle, and literal expectations for the key scenarios.
module tb_mem_bus_arbiter;
    localparam int unsigned MAXW = 15;

    logic        clk, rst_n;
    logic        if_req;
    logic [31:0] if_addr, if_rdata;
    logic        if_ack;
    logic        dm_req, dm_we;
    logic [1:0]  dm_size;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_ack, dm_fault;
    logic        bus_valid, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_strb;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        stall_f, stall_m, bus_err;

    mem_bus_arbiter #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_fault(dm_fault),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_strb(bus_strb),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .stall_f(stall_f), .stall_m(stall_m), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- memory contents seen by the responder ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h100: return 32'h00500093;
            32'h104: return 32'h00A00113;
            32'h200: return 32'h11223344;
            32'h300: return 32'hBEEF1234;
            32'h0C0: return 32'hDEADBEEF;
            default: return a ^ 32'hA5A50000;
        endcase
    endfunction

    // ---------------- reference model (transaction level) ----------------
    function automatic int nbytes_of(input logic [1:0] size);
        return (size == 2'd1) ? 1 : (size == 2'd2) ? 2 : 4;
    endfunction

    function automatic int lane_of(input int n, input logic [31:0] addr);
        return (int'(addr % 32'd4) / n) * n;
    endfunction

    function automatic logic [31:0] lanes_of(input logic [31:0] wd, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'((wd >> (8 * (i % n))) & 32'hFF);
        return r;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input int n, input int lane);
        logic [31:0] mask;
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
        return (w >> (8 * lane)) & mask;
    endfunction

    bit          m_started = 1'b0;
    bit          m_busy, m_dm, m_valid, m_we, m_ack_if, m_ack_dm, m_err, m_fault;
    int          m_waited, m_n, m_lane;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
    logic [3:0]  m_strb;

    task automatic model_finish(input bit timeout, input logic [31:0] word);
        m_busy  = 1'b0;
        m_valid = 1'b0;
        m_err   = timeout;
        if (m_dm) begin
            m_ack_dm   = 1'b1;
            m_dm_rdata = timeout ? 32'h0 : extract(word, m_n, m_lane);
        end else begin
            m_ack_if   = 1'b1;
            m_if_rdata = timeout ? 32'h0 : word;
        end
    endtask

    always @(posedge clk) begin
        bit mis;
        m_started = 1'b1;
        if (!rst_n) begin
            m_busy = 0; m_valid = 0; m_ack_if = 0; m_ack_dm = 0; m_err = 0; m_fault = 0;
            m_if_rdata = '0; m_dm_rdata = '0;
        end else if (m_ack_if || m_ack_dm) begin
            m_ack_if = 0; m_ack_dm = 0; m_err = 0; m_fault = 0;
        end else if (m_busy) begin
            if (bus_ready) model_finish(1'b0, bus_rdata);
            else begin
                m_waited++;
                if (m_waited >= int'(MAXW)) model_finish(1'b1, 32'h0);
            end
        end else if (dm_req && dm_size != 2'b00) begin
            m_dm   = 1'b1;
            m_n    = nbytes_of(dm_size);
            m_lane = lane_of(m_n, dm_addr);
`ifdef MISALIGN_TRAP_EN
            mis = (m_n > 1) && (int'(dm_addr % 32'(m_n)) != 0);
`else
            mis = 1'b0;
`endif
            if (mis) begin
                m_ack_dm = 1'b1;
                m_fault  = 1'b1;
            end else begin
                m_busy = 1; m_waited = 0; m_valid = 1; m_we = dm_we;
                m_addr  = dm_addr & ~32'h3;
                m_strb  = 4'(((1 << m_n) - 1) << m_lane);
                m_wdata = lanes_of(dm_wdata, m_n);
            end
        end else if (if_req) begin
            m_dm = 0; m_n = 4; m_lane = 0;
            m_busy = 1; m_waited = 0; m_valid = 1; m_we = 0;
            m_addr = if_addr & ~32'h3;
            m_strb = 4'hF;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_started) begin
            check("bus_valid", 32'(bus_valid), 32'(m_valid));
            if (m_valid) begin
                check("bus_addr", bus_addr, m_addr);
                check("bus_strb", 32'(bus_strb), 32'(m_strb));
                check("bus_we", 32'(bus_we), 32'(m_we));
                if (m_we) check("bus_wdata", bus_wdata, m_wdata);
            end
            check("if_ack", 32'(if_ack), 32'(m_ack_if));
            check("dm_ack", 32'(dm_ack), 32'(m_ack_dm));
            check("bus_err", 32'(bus_err), 32'(m_err && (m_ack_if || m_ack_dm)));
            check("dm_fault", 32'(dm_fault), 32'(m_fault && m_ack_dm));
            check("if_rdata", if_rdata, m_if_rdata);
            check("dm_rdata", dm_rdata, m_dm_rdata);
            check("stall_f", 32'(stall_f), 32'(if_req && !m_ack_if));
            check("stall_m", 32'(stall_m), 32'((dm_req && dm_size != 2'b00) && !m_ack_dm));
        end
    end

    // ---------------- memory responder ----------------
    int          rsp_delay = 0;
    int          rsp_wait  = 0;
    bit          rsp_force = 1'b0;
    int          n_valid_cycles = 0;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_strb;
    logic        obs_we;

    always @(posedge clk) begin
        #1;
        if (!rsp_force) begin
            if (bus_valid) begin
                n_valid_cycles++;
                if (rsp_wait == rsp_delay) begin
                    bus_ready = 1'b1;
                    bus_rdata = mem_word(bus_addr);
                    obs_addr  = bus_addr;
                    obs_wdata = bus_wdata;
                    obs_strb  = bus_strb;
                    obs_we    = bus_we;
                end else begin
                    bus_ready = 1'b0;
                    bus_rdata = 32'hDEAD0000 | 32'(rsp_wait);
                end
                rsp_wait++;
            end else begin
                bus_ready = 1'b0;
                rsp_wait  = 0;
            end
        end
    end

    // ---------------- requesters ----------------
    task automatic if_txn(input logic [31:0] addr, output int lat, output logic err);
        bit got;
        got = 0; lat = 0; err = 0;
        if_req = 1'b1; if_addr = addr;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            lat++;
            if (if_ack) begin got = 1; err = bus_err; end
        end
        check("if_ack_seen", 32'(got), 32'd1);
        if_req = 1'b0;
    endtask

    task automatic dm_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic err,
                          output logic fault);
        bit got;
        got = 0; lat = 0; err = 0; fault = 0;
        dm_req = 1'b1; dm_we = we; dm_size = size; dm_addr = addr; dm_wdata = wdata;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            lat++;
            if (dm_ack) begin got = 1; err = bus_err; fault = dm_fault; end
        end
        check("dm_ack_seen", 32'(got), 32'd1);
        dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat_a, lat_b, vc0;
        logic e_a, e_b, f_a;
        rst_n = 1'b0;
        if_req = 0; if_addr = '0;
        dm_req = 0; dm_we = 0; dm_size = 2'b00; dm_addr = '0; dm_wdata = '0;
        bus_ready = 0; bus_rdata = '0;
        repeat (2) tick();
        check("rst_bus_valid", 32'(bus_valid), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_dm_ack", 32'(dm_ack), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single fetch, minimum latency
        rsp_delay = 0;
        if_txn(32'h100, lat_a, e_a);
        check("fetch_lat", 32'(lat_a), 32'd2);
        check("fetch_addr", obs_addr, 32'h100);
        check("fetch_strb", 32'(obs_strb), 32'hF);
        check("fetch_rdata", if_rdata, 32'h00500093);
        check("fetch_err", 32'(e_a), 32'd0);
        tick();

        // Simultaneous data (LW 0x200) and fetch: data first
        fork
            dm_txn(1'b0, 2'b11, 32'h200, 32'h0, lat_a, e_a, f_a);
            if_txn(32'h104, lat_b, e_b);
        join
        check("sim_dm_lat", 32'(lat_a), 32'd2);
        check("sim_if_lat", 32'(lat_b), 32'd5);
        check("sim_dm_rdata", dm_rdata, 32'h11223344);
        check("sim_if_rdata", if_rdata, 32'h00A00113);
        tick();

        // SB to 0x203
        dm_txn(1'b1, 2'b01, 32'h203, 32'h000000AB, lat_a, e_a, f_a);
        check("sb_addr", obs_addr, 32'h200);
        check("sb_strb", 32'(obs_strb), 32'h8);
        check("sb_wdata", obs_wdata, 32'hABABABAB);
        check("sb_we", 32'(obs_we), 32'd1);
        tick();

        // SH to 0x102
        dm_txn(1'b1, 2'b10, 32'h102, 32'h00001234, lat_a, e_a, f_a);
        check("sh_strb", 32'(obs_strb), 32'hC);
        check("sh_wdata", obs_wdata, 32'h12341234);
        tick();

        // LH 0x302
        dm_txn(1'b0, 2'b10, 32'h302, 32'h0, lat_a, e_a, f_a);
        check("lh_rdata", dm_rdata, 32'h0000BEEF);
        tick();

        // LB 0x0C1
        dm_txn(1'b0, 2'b01, 32'h0C1, 32'h0, lat_a, e_a, f_a);
        check("lb_rdata", dm_rdata, 32'h000000BE);
        tick();

        // Misaligned LW 0x401
        vc0 = n_valid_cycles;
        dm_txn(1'b0, 2'b11, 32'h401, 32'h0, lat_a, e_a, f_a);
`ifdef MISALIGN_TRAP_EN
        check("mis_lat", 32'(lat_a), 32'd1);
        check("mis_fault", 32'(f_a), 32'd1);
        check("mis_no_bus", 32'(n_valid_cycles - vc0), 32'd0);
        check("mis_rdata_held", dm_rdata, 32'h000000BE);
`else
        check("mis_lat", 32'(lat_a), 32'd2);
        check("mis_fault", 32'(f_a), 32'd0);
        check("mis_addr", obs_addr, 32'h400);
        check("mis_rdata", dm_rdata, 32'hA5A50400);
`endif
        tick();

        // Fetch with three wait cycles
        rsp_delay = 3;
        if_txn(32'h100, lat_a, e_a);
        check("fetch_wait_lat", 32'(lat_a), 32'd5);
        tick();

        // Timeouts: data then fetch
        rsp_delay = 1000;
        dm_txn(1'b0, 2'b10, 32'h302, 32'h0, lat_a, e_a, f_a);
        check("to_dm_lat", 32'(lat_a), 32'd16);
        check("to_dm_err", 32'(e_a), 32'd1);
        check("to_dm_rdata", dm_rdata, 32'h0);
        tick();
        if_txn(32'h104, lat_a, e_a);
        check("to_if_lat", 32'(lat_a), 32'd16);
        check("to_if_err", 32'(e_a), 32'd1);
        check("to_if_rdata", if_rdata, 32'h0);
        rsp_delay = 0;
        tick();

        // dm_size==00 is ignored, and does not block a fetch
        vc0 = n_valid_cycles;
        dm_req = 1'b1; dm_size = 2'b00; dm_addr = 32'h600;
        repeat (4) tick();
        check("size0_no_bus", 32'(n_valid_cycles - vc0), 32'd0);
        if_txn(32'h100, lat_a, e_a);
        check("size0_fetch_lat", 32'(lat_a), 32'd2);
        dm_req = 1'b0;
        tick();

        // Reset during a waiting transfer, with bus_ready in the same cycle
        rsp_delay = 1000;
        dm_req = 1'b1; dm_we = 1'b1; dm_size = 2'b11; dm_addr = 32'h500; dm_wdata = 32'hCAFEF00D;
        repeat (5) tick();
        rsp_force = 1'b1;
        bus_ready = 1'b1; bus_rdata = 32'hFFFFFFFF;
        rst_n = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'b00;
        tick();
        check("rmid_valid", 32'(bus_valid), 32'd0);
        check("rmid_dm_ack", 32'(dm_ack), 32'd0);
        check("rmid_if_ack", 32'(if_ack), 32'd0);
        check("rmid_err", 32'(bus_err), 32'd0);
        check("rmid_addr", bus_addr, 32'd0);
        check("rmid_wdata", bus_wdata, 32'd0);
        check("rmid_strb", 32'(bus_strb), 32'd0);
        check("rmid_we", 32'(bus_we), 32'd0);
        check("rmid_if_rdata", if_rdata, 32'd0);
        check("rmid_dm_rdata", dm_rdata, 32'd0);
        rst_n = 1'b1;
        bus_ready = 1'b0;
        rsp_force = 1'b0;
        rsp_delay = 0;
        tick();
        if_txn(32'h100, lat_a, e_a);
        check("post_rst_lat", 32'(lat_a), 32'd2);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
